// File: rtl/ahb_subordinate_memory.sv
// AHB5 subordinate backed by a local byte-addressed memory. It inserts a fixed number
// of wait states per valid transfer and answers illegal accesses with the two-cycle ERROR.
module ahb_subordinate_memory #(
  parameter int unsigned            ADDR_WIDTH    = 32,
  parameter int unsigned            DATA_WIDTH    = 32,
  parameter int unsigned            MEM_ADDR_BITS = 12,
  parameter int unsigned            WAIT_STATES   = 0,
  parameter logic [ADDR_WIDTH-1:0]  MIN_ADDR      = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0]  MAX_ADDR      = 32'h0000_0FFF
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata,
  output logic                    hexokay
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(STRB_W);
  localparam int unsigned MEM_BYTES = 1 << MEM_ADDR_BITS;

  typedef enum logic [1:0] {
    ST_RDY  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_e;

  state_e                   state_q;
  logic [3:0]               wait_cnt_q;
  logic                     hreadyout_q;
  logic                     hresp_q;
  logic                     pend_q;
  logic                     write_q;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [2:0]               size_q;
  logic [7:0]               mem_q [MEM_BYTES];

  logic                     accept_s;
  logic                     illegal_s;
  logic                     below_min_s;
  logic                     above_max_s;
  logic                     too_big_s;
  logic                     misaligned_s;
  logic [ADDR_WIDTH-1:0]    align_mask_s;
  logic                     final_s;
  logic                     commit_s;
  logic [STRB_W-1:0]        wr_lanes_s;
  logic [DATA_WIDTH-1:0]    rdata_s;
  logic                     unused_s;

  function automatic logic [STRB_W-1:0] lane_mask(input logic [2:0] size,
                                                  input logic [LANE_BITS-1:0] offset);
    int unsigned nbytes;
    int unsigned first;
    nbytes = 32'd1 << size;
    first  = 32'(offset);
    for (int unsigned i = 0; i < STRB_W; i++) begin
      lane_mask[i] = (i >= first) && (i < first + nbytes);
    end
  endfunction

  // Bounds use the borrow of a widened subtraction, so a zero MIN_ADDR needs no special case
  always_comb begin
    accept_s     = hselx & hready & htrans[1];
    below_min_s  = 1'(({1'b0, haddr} - {1'b0, MIN_ADDR}) >> ADDR_WIDTH);
    above_max_s  = 1'(({1'b0, MAX_ADDR} - {1'b0, haddr}) >> ADDR_WIDTH);
    too_big_s    = (32'd1 << hsize) > STRB_W;
    align_mask_s = ADDR_WIDTH'((32'd1 << hsize) - 32'd1);
    misaligned_s = |(haddr & align_mask_s);
    illegal_s    = below_min_s | above_max_s | too_big_s | misaligned_s;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_RDY;
      wait_cnt_q  <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      pend_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= 3'd0;
    end else begin
      case (state_q)
        ST_RDY, ST_ERR2: begin
          if (accept_s) begin
            addr_q  <= haddr[MEM_ADDR_BITS-1:0];
            write_q <= hwrite;
            size_q  <= hsize;
            if (illegal_s) begin
              state_q     <= ST_ERR1;
              pend_q      <= 1'b0;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES != 0) begin
              state_q     <= ST_WAIT;
              wait_cnt_q  <= 4'(WAIT_STATES - 1);
              pend_q      <= 1'b1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= ST_RDY;
              pend_q      <= 1'b1;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= ST_RDY;
            pend_q      <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            state_q     <= ST_RDY;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= ST_RDY;
          wait_cnt_q  <= 4'd0;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          pend_q      <= 1'b0;
        end
      endcase
    end
  end

  // The final OKAY data cycle is RDY with a transfer still pending
  always_comb begin
    final_s    = (state_q == ST_RDY) & pend_q;
    commit_s   = final_s & write_q & ~hreset;
    wr_lanes_s = hwstrb & lane_mask(size_q, addr_q[LANE_BITS-1:0]);
  end

  always_ff @(posedge hclk) begin
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (commit_s && wr_lanes_s[i]) begin
        mem_q[{addr_q[MEM_ADDR_BITS-1:LANE_BITS], LANE_BITS'(i)}] <= hwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_s = '0;
    if (final_s && !write_q) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        rdata_s[8*i +: 8] = mem_q[{addr_q[MEM_ADDR_BITS-1:LANE_BITS], LANE_BITS'(i)}];
      end
    end else begin
      rdata_s = '0;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = rdata_s;
  assign hexokay   = 1'b0;
  assign unused_s  = ^{hburst, hprot, htrans[0]};

endmodule

// File: tb/tb_ahb_subordinate_memory.sv
// Directed bench for ahb_subordinate_memory: one zero-wait and one two-wait instance
// share a bus; dut_sel picks which one is addressed and drives the combined hready.
module tb_ahb_subordinate_memory;

  logic        hclk = 1'b0;
  logic        hreset, hselx, hwrite, dut_sel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot, hwstrb;
  logic        ro0, rs0, ex0, ro2, rs2, ex2;
  logic [31:0] rd0, rd2;
  logic        hready_s, hresp_s;
  logic [31:0] hrdata_s;
  int          checks = 0;
  int          errors = 0;

  always #5 hclk = ~hclk;

  assign hready_s = dut_sel ? ro2 : ro0;
  assign hresp_s  = dut_sel ? rs2 : rs0;
  assign hrdata_s = dut_sel ? rd2 : rd0;

  ahb_subordinate_memory #(.WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hselx(hselx & ~dut_sel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready_s),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0), .hexokay(ex0));

  ahb_subordinate_memory #(.WAIT_STATES(2)) u_dut2 (
    .hclk(hclk), .hreset(hreset), .hselx(hselx & dut_sel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hwdata(hwdata), .hwstrb(hwstrb), .hready(hready_s),
    .hreadyout(ro2), .hresp(rs2), .hrdata(rd2), .hexokay(ex2));

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated transfer: address phase, then data phase until hready, then idle
  task automatic single(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [3:0] st,
                        output int waits, output logic first_resp,
                        output logic last_resp, output logic [31:0] rd);
    hselx = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; hburst = 3'b000;
    cyc();
    hselx = 1'b0; htrans = 2'b00; hwdata = wd; hwstrb = st;
    first_resp = hresp_s;
    waits = 0;
    while (hready_s !== 1'b1 && waits < 40) begin
      waits++;
      cyc();
    end
    last_resp = hresp_s;
    rd = hrdata_s;
    cyc();
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input logic [3:0] st, input int exp_waits);
    int waits; logic fr, lr; logic [31:0] rd;
    single(1'b1, a, sz, wd, st, waits, fr, lr, rd);
    check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    check({tag, "_resp"}, 32'(lr), 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [31:0] exp, input int exp_waits);
    int waits; logic fr, lr; logic [31:0] rd;
    single(1'b0, a, 3'b010, 32'd0, 4'h0, waits, fr, lr, rd);
    check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    check({tag, "_resp"}, 32'(lr), 32'd0);
    check({tag, "_data"}, rd, exp);
  endtask

  task automatic do_err(input string tag, input logic w, input logic [31:0] a,
                        input logic [2:0] sz);
    int waits; logic fr, lr; logic [31:0] rd;
    single(w, a, sz, 32'hFFFF_FFFF, 4'hF, waits, fr, lr, rd);
    check({tag, "_waits"}, 32'(waits), 32'd1);
    check({tag, "_resp1"}, 32'(fr), 32'd1);
    check({tag, "_resp2"}, 32'(lr), 32'd1);
    check({tag, "_rdata"}, rd, 32'd0);
    check({tag, "_after_rdy"}, 32'(hready_s), 32'd1);
    check({tag, "_after_resp"}, 32'(hresp_s), 32'd0);
  endtask

  // Present one address phase while the previous one's data phase finishes
  task automatic pipe_step(input string tag, input logic [1:0] tr, input logic [31:0] a,
                           input logic w, input logic [31:0] wd, input int exp_waits,
                           input logic chk_rd, input logic [31:0] exp_rd);
    int waits;
    hselx = 1'b1; htrans = tr; haddr = a; hwrite = w; hsize = 3'b010; hburst = 3'b011;
    hwdata = wd; hwstrb = 4'hF;
    waits = 0;
    while (hready_s !== 1'b1 && waits < 40) begin
      waits++;
      cyc();
    end
    check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
    check({tag, "_resp"}, 32'(hresp_s), 32'd0);
    if (chk_rd) begin
      check({tag, "_data"}, hrdata_s, exp_rd);
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset = 1'b1; hselx = 1'b0; htrans = 2'b00; haddr = 32'd0; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'h3; hwdata = 32'd0; hwstrb = 4'h0;
    dut_sel = 1'b0;
    repeat (3) cyc();
    hreset = 1'b0;
    cyc();
    check("rst_ready0", 32'(ro0), 32'd1);
    check("rst_resp0", 32'(rs0), 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_exokay0", 32'(ex0), 32'd0);
    check("rst_ready2", 32'(ro2), 32'd1);
    check("rst_exokay2", 32'(ex2), 32'd0);

    do_write("w10", 32'h10, 3'b010, 32'hDEAD_BEEF, 4'hF, 0);
    do_read("r10", 32'h10, 32'hDEAD_BEEF, 0);
    do_write("wb13", 32'h13, 3'b000, 32'hAA00_0000, 4'hF, 0);
    do_read("r10b", 32'h10, 32'hAAAD_BEEF, 0);

    do_write("w00", 32'h0, 3'b010, 32'h0BAD_F00D, 4'hF, 0);
    do_err("err_max", 1'b1, 32'h1000, 3'b010);
    do_read("r00a", 32'h0, 32'h0BAD_F00D, 0);
    do_err("err_mis", 1'b1, 32'h1, 3'b001);
    do_err("err_dw", 1'b1, 32'h0, 3'b011);
    do_read("r00b", 32'h0, 32'h0BAD_F00D, 0);
    do_err("err_rd", 1'b0, 32'h2, 3'b010);

    hselx = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'b010;
    cyc();
    hwdata = 32'h1234_5678; hwstrb = 4'hF; haddr = 32'h40; hwrite = 1'b0;
    check("pipe_w_ready", 32'(hready_s), 32'd1);
    cyc();
    hselx = 1'b0; htrans = 2'b00;
    check("pipe_r_ready", 32'(hready_s), 32'd1);
    check("pipe_r_resp", 32'(hresp_s), 32'd0);
    check("pipe_r_data", hrdata_s, 32'h1234_5678);
    cyc();
    do_write("wh42", 32'h42, 3'b001, 32'hCAFE_0000, 4'b0100, 0);
    do_read("r40", 32'h40, 32'h12FE_5678, 0);

    dut_sel = 1'b1;
    cyc();
    do_write("w80", 32'h80, 3'b010, 32'h1111_1111, 4'hF, 2);
    hselx = 1'b1; htrans = 2'b10; haddr = 32'h80; hwrite = 1'b1; hsize = 3'b010;
    cyc();
    hselx = 1'b0; htrans = 2'b00; hwdata = 32'h5555_5555; hwstrb = 4'hF;
    check("midwait_ready", 32'(hready_s), 32'd0);
    hreset = 1'b1;
    cyc();
    cyc();
    hreset = 1'b0;
    check("rstw_ready", 32'(hready_s), 32'd1);
    check("rstw_resp", 32'(hresp_s), 32'd0);
    check("rstw_rdata", hrdata_s, 32'd0);
    cyc();
    check("rstw_ready_next", 32'(hready_s), 32'd1);
    do_read("r80", 32'h80, 32'h1111_1111, 2);
    do_err("err_ws2", 1'b1, 32'h1000, 3'b010);

    pipe_step("bw0", 2'b10, 32'h20, 1'b1, 32'h0,         0, 1'b0, 32'h0);
    pipe_step("bw1", 2'b11, 32'h24, 1'b1, 32'hA0A0_0001, 2, 1'b0, 32'h0);
    pipe_step("bwb", 2'b01, 32'h28, 1'b1, 32'hB0B0_0002, 2, 1'b0, 32'h0);
    pipe_step("bw2", 2'b11, 32'h28, 1'b1, 32'h0,         0, 1'b0, 32'h0);
    pipe_step("bw3", 2'b11, 32'h2C, 1'b1, 32'hC0C0_0003, 2, 1'b0, 32'h0);
    pipe_step("bwe", 2'b00, 32'h0,  1'b0, 32'hD0D0_0004, 2, 1'b0, 32'h0);
    pipe_step("br0", 2'b10, 32'h20, 1'b0, 32'h0,         0, 1'b0, 32'h0);
    pipe_step("br1", 2'b11, 32'h24, 1'b0, 32'h0,         2, 1'b1, 32'hA0A0_0001);
    pipe_step("br2", 2'b11, 32'h28, 1'b0, 32'h0,         2, 1'b1, 32'hB0B0_0002);
    pipe_step("br3", 2'b11, 32'h2C, 1'b0, 32'h0,         2, 1'b1, 32'hC0C0_0003);
    pipe_step("bre", 2'b00, 32'h0,  1'b0, 32'h0,         2, 1'b1, 32'hD0D0_0004);
    hselx = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
